spi_slave_regfile: RTL and testbench
====================================

// Module: spi_slave_regfile
// PURPOSE
//  Parametrised SPI slave register file, the successor to the fixed 8-bit slave. It is fully synchronous to the system clock clk.
//  SPI pins are oversampled; SCLK is never used as a clock. Supports all four SPI modes, configurable address/data width and depth.
//  Adds burst auto-increment, frame abort and a local write-notify port. Sits between the top-level SPI pins and the register consumers.
// PARAMETERS
//  ADDR_W    8    address bits per frame
//  DATA_W    8    data bits per word
//  DEPTH     256  implemented words (<= 2**ADDR_W); addresses >= DEPTH are out of range
//  CPOL      0    SCLK idle level
//  CPHA      0    0: sample on leading edge; 1: sample on trailing edge
// PORTS
//  clk       in   1       system clock; the only clock
//  rst       in   1       synchronous, active-high reset
//  sclk      in   1       SPI clock (asynchronous input)
//  ss_n      in   1       slave select, active low (asynchronous input)
//  mosi      in   1       master-out data (asynchronous input)
//  miso      out  1       slave-out data, MSB first
//  miso_oe   out  1       miso drive enable; the top level builds the tristate
//  wr_valid  out  1       one-cycle pulse on each committed write
//  wr_addr   out  ADDR_W  address of the committed write
//  wr_data   out  DATA_W  data of the committed write
//  frame_err out  1       one-cycle pulse when ss_n rises mid-word
// BEHAVIOUR
//  - sclk, ss_n and mosi each pass through a 2-flop synchronizer. Edges are detected on the synchronized sclk.
//    Sample edge = leading edge XOR CPHA. Shift edge = the opposite edge. Requires SCLK period >= 8 clk.
//  - Frame: 1 cmd bit (1=write, 0=read), then ADDR_W address bits, then N*DATA_W data bits. All fields MSB first.
//  - FSM states IDLE, CMD, ADDR, DATA:
//    IDLE->CMD on ss_n falling.
//    CMD->ADDR after 1 sample edge.
//    ADDR->DATA after ADDR_W samples.
//    DATA stays in DATA across words.
//    Any state->IDLE on ss_n high.
//  - Write: mosi is shifted into a holding register. On the sample edge of bit DATA_W-1, mem[addr] is updated and wr_valid pulses
//    on the following clk with wr_addr/wr_data. Out-of-range address: write dropped, no wr_valid.
//  - Read: the word mem[addr] is loaded at the first shift edge after the last address bit is sampled. It shifts left on each
//    subsequent shift edge. Out-of-range reads return 0.
//  - Burst: after each complete word, addr increments and wraps from DEPTH-1 to 0. The next word continues without a new cmd or address.
//    For a read, the next word is loaded at the shift edge following the last sampled bit.
//  - miso_oe = 1 only in DATA state of a read frame; otherwise miso=0 and miso_oe=0.
//  - Abort: ss_n high with a partial word (0 < bit count < DATA_W) discards it (no mem update) and pulses frame_err.
//    ss_n high with 0 data bits, or on a word boundary, is a clean end with no error.
//  - Simultaneous ss_n rise and final sample edge in the same clk: the sample is taken first and the word commits. No frame_err.
//  - rst: state=IDLE, all counters 0, miso=0, miso_oe=0, wr_valid=0, wr_addr=0, wr_data=0, frame_err=0, mem cleared to 0.
//    Reset mid-frame abandons the frame with no pulse. After reset, the slave waits for a fresh ss_n falling edge.
// STRUCTURE
//  - Shared package: state encoding (IDLE/CMD/ADDR/DATA), CMD_WRITE/CMD_READ constants, sync depth constant.
//  - One sub-module: spi_edge_sync (2-flop sync of sclk/ss_n/mosi; outputs sample_pulse, shift_pulse, ss_fall, ss_rise,
//    parametrised by CPOL/CPHA).
//  - Memory array, FSM and shifters stay in this module.
// TESTING
//  1. Mode 0, write cmd, addr 0xE9, data 0xB9 -> wr_valid 1 clk, wr_addr=0xE9, wr_data=0xB9.
//     A following read frame at 0xE9 -> miso bits 1,0,1,1,1,0,0,1.
//  2. Burst write at 0xFF with 0x11,0x22,0x33 (DEPTH=256) -> three wr_valid pulses at addr 0xFF,0x00,0x01.
//     Burst read from 0xFF returns 0x11,0x22,0x33.
//  3. Write to 0x10, ss_n raised after 4 data bits -> frame_err pulse, no wr_valid, mem[0x10] still 0.
//  4. CPOL=1,CPHA=1, read at 0x05 after writing 0xA5 -> miso 1,0,1,0,0,1,0,1, each bit stable across its sample edge;
//     miso_oe low outside DATA.
//  5. DEPTH=200: write 0xAA to 0xC8 -> no wr_valid; read 0xC8 -> 0x00.
//  6. rst asserted mid-address of a write -> outputs at reset values next clk, no wr_valid.
//     A new frame then writes 0x3C to 0x01 correctly.

Source files
------------

// File: rtl/spi_slave_regfile_pkg.sv
// Shared types and constants for the SPI slave register file.
package spi_slave_regfile_pkg;

  // Frame-level protocol state.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmd  = 2'd1,
    StAddr = 2'd2,
    StData = 2'd3
  } spi_state_e;

  // Value of the first frame bit.
  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  // Flops in each pin synchronizer.
  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_slave_regfile_edge_sync.sv
// Synchronizes the SPI pins into clk and turns synchronized sclk transitions into
// mode-dependent sample/shift strobes, plus ss_n edge strobes.
module spi_edge_sync
  import spi_slave_regfile_pkg::*;
#(
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0
) (
  input  logic clk,
  input  logic sclk,
  input  logic ss_n,
  input  logic mosi,
  output logic sample_pulse,
  output logic shift_pulse,
  output logic ss_fall,
  output logic ss_rise,
  output logic mosi_sync
);

  logic [SYNC_DEPTH-1:0] sclk_sync_q;
  logic [SYNC_DEPTH-1:0] ss_sync_q;
  logic [SYNC_DEPTH-1:0] mosi_sync_q;
  logic                  sclk_prev_q;
  logic                  ss_prev_q;

  logic sclk_s;
  logic sclk_rise;
  logic sclk_fall;
  logic lead_pulse;
  logic trail_pulse;

  // Synchronizer chains and edge-history flops. Deliberately not reset: they always track
  // the pins, so a reset in the middle of a frame never fabricates an ss_n falling edge.
  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_DEPTH-2:0], sclk};
    ss_sync_q   <= {ss_sync_q[SYNC_DEPTH-2:0], ss_n};
    mosi_sync_q <= {mosi_sync_q[SYNC_DEPTH-2:0], mosi};
    sclk_prev_q <= sclk_sync_q[SYNC_DEPTH-1];
    ss_prev_q   <= ss_sync_q[SYNC_DEPTH-1];
  end

  // Edge detection; leading edge is the transition away from the CPOL idle level.
  always_comb begin
    sclk_s       = sclk_sync_q[SYNC_DEPTH-1];
    sclk_rise    = sclk_s & ~sclk_prev_q;
    sclk_fall    = ~sclk_s & sclk_prev_q;
    lead_pulse   = CPOL ? sclk_fall : sclk_rise;
    trail_pulse  = CPOL ? sclk_rise : sclk_fall;
    sample_pulse = CPHA ? trail_pulse : lead_pulse;
    shift_pulse  = CPHA ? lead_pulse : trail_pulse;
    ss_fall      = ~ss_sync_q[SYNC_DEPTH-1] & ss_prev_q;
    ss_rise      = ss_sync_q[SYNC_DEPTH-1] & ~ss_prev_q;
    mosi_sync    = mosi_sync_q[SYNC_DEPTH-1];
  end

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI slave register file, oversampled in the clk domain. Frames are
// cmd bit, address, then a burst of data words with address auto-increment.
module spi_slave_regfile
  import spi_slave_regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter bit          CPOL   = 1'b0,
  parameter bit          CPHA   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ss_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_err
);

  localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic sample_pulse;
  logic shift_pulse;
  logic ss_fall;
  logic ss_rise;
  logic mosi_s;

  spi_edge_sync #(
    .CPOL(CPOL),
    .CPHA(CPHA)
  ) u_edge_sync (
    .clk         (clk),
    .sclk        (sclk),
    .ss_n        (ss_n),
    .mosi        (mosi),
    .sample_pulse(sample_pulse),
    .shift_pulse (shift_pulse),
    .ss_fall     (ss_fall),
    .ss_rise     (ss_rise),
    .mosi_sync   (mosi_s)
  );

  spi_state_e              state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    cmd_q, cmd_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       shreg_q, shreg_d;
  logic [DATA_W-1:0]       tx_q, tx_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]       wr_data_q, wr_data_d;
  logic                    frame_err_q, frame_err_d;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic                    addr_in_range;
  logic [DATA_W-1:0]       rd_word;
  logic [ADDR_W-1:0]       addr_inc;

  // Next-state, datapath and output-pulse logic for the frame FSM.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    shreg_d     = shreg_q;
    tx_d        = tx_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    mem_we      = 1'b0;

    addr_in_range = (32'(addr_q) < DEPTH);
    rd_word       = addr_in_range ? mem_q[addr_q[IDX_W-1:0]] : '0;
    addr_inc      = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

    unique case (state_q)
      StIdle: begin
        if (ss_fall) begin
          state_d   = StCmd;
          bit_cnt_d = '0;
          addr_d    = '0;
          shreg_d   = '0;
          tx_d      = '0;
        end
      end
      StCmd: begin
        if (sample_pulse) begin
          cmd_d     = mosi_s;
          bit_cnt_d = '0;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (sample_pulse) begin
          addr_d = {addr_q[ADDR_W-2:0], mosi_s};
          if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = StData;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      StData: begin
        // On a word boundary the shift edge loads the next word instead of shifting.
        if (shift_pulse && cmd_q == CMD_READ) begin
          tx_d = (bit_cnt_q == '0) ? rd_word : {tx_q[DATA_W-2:0], 1'b0};
        end
        if (sample_pulse) begin
          shreg_d = {shreg_q[DATA_W-2:0], mosi_s};
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            addr_d    = addr_inc;
            if (cmd_q == CMD_WRITE && addr_in_range) begin
              mem_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = shreg_d;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // ss_n rising ends the frame after any same-cycle sample has been taken.
    if (ss_rise && state_q != StIdle) begin
      state_d = StIdle;
      if (state_q == StData && bit_cnt_d != '0) begin
        frame_err_d = 1'b1;
      end
    end
  end

  // FSM, shifters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      cmd_q       <= CMD_READ;
      addr_q      <= '0;
      shreg_q     <= '0;
      tx_q        <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register array; cleared by reset, written when a full in-range word commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[addr_q[IDX_W-1:0]] <= shreg_d;
    end
  end

  // Output drive: miso only enabled while shifting out read data.
  always_comb begin
    miso_oe   = (state_q == StData) && (cmd_q == CMD_READ);
    miso      = miso_oe & tx_q[DATA_W-1];
    wr_valid  = wr_valid_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
    frame_err = frame_err_q;
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Bench for spi_slave_regfile: three instances (mode 0 / mode 3 / DEPTH=200) driven by a
// bit-level SPI master task and checked against an array model of the register file.
module tb_spi_slave_regfile;

  localparam int H = 5;  // clk cycles per SCLK half period

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk0, sclk1, mosi;
  logic [2:0] ss_n;
  logic [2:0] miso, miso_oe, wr_valid, frame_err;
  logic [7:0] wr_addr [3];
  logic [7:0] wr_data [3];

  always #5 clk = ~clk;

  spi_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .CPOL(1'b0), .CPHA(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .ss_n(ss_n[0]), .mosi(mosi),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .wr_valid(wr_valid[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .frame_err(frame_err[0])
  );
  spi_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .CPOL(1'b1), .CPHA(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .ss_n(ss_n[1]), .mosi(mosi),
    .miso(miso[1]), .miso_oe(miso_oe[1]), .wr_valid(wr_valid[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .frame_err(frame_err[1])
  );
  spi_slave_regfile #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .CPOL(1'b0), .CPHA(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .sclk(sclk0), .ss_n(ss_n[2]), .mosi(mosi),
    .miso(miso[2]), .miso_oe(miso_oe[2]), .wr_valid(wr_valid[2]), .wr_addr(wr_addr[2]),
    .wr_data(wr_data[2]), .frame_err(frame_err[2])
  );

  logic [7:0]  mdl [3][256];
  int unsigned dep [3] = '{256, 256, 200};
  logic [7:0]  tx_words[$];
  logic [7:0]  rx_words[$];
  logic [7:0]  exp_rx[$];
  logic [17:0] wr_log[$];
  logic [17:0] exp_log[$];
  int          ferr_cnt [3];
  int          cur, oe_bad, unstable;
  int          checks, passes;
  logic        cur_miso, cur_oe;

  always_comb begin
    cur_miso = miso[cur];
    cur_oe   = miso_oe[cur];
  end

  // Log every write pulse and frame-error pulse, sampled mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (wr_valid[k] === 1'b1) wr_log.push_back({2'(k), wr_addr[k], wr_data[k]});
      if (frame_err[k] === 1'b1) ferr_cnt[k]++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic set_sclk(input logic v);
    if (cur == 1) sclk1 = v;
    else sclk0 = v;
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 256; a++) mdl[d][a] = 8'h00;
  endtask

  // Bit-level SPI master; optionally pulses rst just before frame bit rst_at.
  task automatic spi_frame(input int id, input bit wr, input logic [7:0] a, input int ndata,
                           input int rst_at);
    bit cpol, cpha;
    logic b, pre;
    logic [7:0] rxw;
    int total, d;
    cpol = (id == 1);
    cpha = (id == 1);
    cur = id;
    oe_bad = 0;
    unstable = 0;
    rx_words.delete();
    rxw = 8'h00;
    ss_n[id] = 1'b0;
    wait_clks(H);
    total = 9 + ndata;
    for (int i = 0; i < total; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        wait_clks(1);
        check("rst_wr_valid", wr_valid[id], 0);
        check("rst_wr_addr", wr_addr[id], 0);
        check("rst_wr_data", wr_data[id], 0);
        check("rst_miso_oe", {miso[id], miso_oe[id]}, 0);
        check("rst_frame_err", frame_err[id], 0);
        rst = 1'b0;
      end
      d = i - 9;
      if (i == 0) b = wr;
      else if (i < 9) b = a[8-i];
      else if (wr) b = tx_words[d/8][7-(d%8)];
      else b = 1'b0;
      if (!cpha) mosi = b;
      else begin
        set_sclk(~cpol);
        mosi = b;
      end
      wait_clks(H);
      pre = cur_miso;
      if ((i >= 9 && !wr) ? (cur_oe !== 1'b1) : (cur_oe !== 1'b0)) oe_bad++;
      set_sclk(cpha ? cpol : ~cpol);
      wait_clks(H);
      if (i >= 9 && !wr) begin
        if (cur_miso !== pre) unstable++;
        rxw = {rxw[6:0], pre};
        if ((d % 8) == 7) rx_words.push_back(rxw);
      end
      if (!cpha) set_sclk(cpol);
    end
    wait_clks(H);
    ss_n[id] = 1'b1;
    wait_clks(6);
  endtask

  // Runs one frame and compares everything observable against the array model.
  task automatic run_frame(input string tag, input int id, input bit wr, input logic [7:0] a,
                           input int ndata, input int rst_at);
    logic [7:0] ea;
    int f0;
    exp_log.delete();
    exp_rx.delete();
    wr_log.delete();
    f0 = ferr_cnt[id];
    ea = a;
    if (rst_at < 0) begin
      for (int k = 0; k < ndata / 8; k++) begin
        if (wr) begin
          if (ea < dep[id]) begin
            mdl[id][ea] = tx_words[k];
            exp_log.push_back({2'(id), ea, tx_words[k]});
          end
        end else begin
          exp_rx.push_back((ea < dep[id]) ? mdl[id][ea] : 8'h00);
        end
        ea = (ea == 8'(dep[id] - 1)) ? 8'h00 : ea + 8'h01;
      end
    end else begin
      clear_model();
    end
    spi_frame(id, wr, a, ndata, rst_at);
    check({tag, "_wr_count"}, wr_log.size(), exp_log.size());
    for (int k = 0; k < exp_log.size() && k < wr_log.size(); k++)
      check({tag, "_wr"}, wr_log[k], exp_log[k]);
    if (!wr) begin
      check({tag, "_rd_count"}, rx_words.size(), exp_rx.size());
      for (int k = 0; k < exp_rx.size() && k < rx_words.size(); k++)
        check({tag, "_rd"}, rx_words[k], exp_rx[k]);
      check({tag, "_miso_stable"}, unstable, 0);
    end
    check({tag, "_miso_oe"}, oe_bad, 0);
    check({tag, "_frame_err"}, ferr_cnt[id] - f0, (rst_at < 0 && ndata % 8 != 0) ? 1 : 0);
    check({tag, "_idle_pins"}, {miso[id], miso_oe[id]}, 0);
  endtask

  initial begin
    int id, n;
    logic [7:0] a;
    checks = 0;
    passes = 0;
    rst = 1'b1;
    sclk0 = 1'b0;
    sclk1 = 1'b1;
    mosi = 1'b0;
    ss_n = 3'b111;
    cur = 0;
    for (int k = 0; k < 3; k++) ferr_cnt[k] = 0;
    clear_model();
    wait_clks(5);
    for (int k = 0; k < 3; k++) begin
      check("reset_wr_valid", wr_valid[k], 0);
      check("reset_wr_addr", wr_addr[k], 0);
      check("reset_wr_data", wr_data[k], 0);
      check("reset_miso", {miso[k], miso_oe[k], frame_err[k]}, 0);
    end
    rst = 1'b0;
    wait_clks(3);

    // Single write then read back, mode 0.
    tx_words = '{8'hB9};
    run_frame("t1_wr", 0, 1'b1, 8'hE9, 8, -1);
    check("t1_wr_addr", wr_addr[0], 8'hE9);
    check("t1_wr_data", wr_data[0], 8'hB9);
    tx_words.delete();
    run_frame("t1_rd", 0, 1'b0, 8'hE9, 8, -1);
    check("t1_rd_value", rx_words[0], 8'hB9);

    // Burst across the top of the address space.
    tx_words = '{8'h11, 8'h22, 8'h33};
    run_frame("t2_wr", 0, 1'b1, 8'hFF, 24, -1);
    check("t2_wr_last_addr", wr_addr[0], 8'h01);
    tx_words.delete();
    run_frame("t2_rd", 0, 1'b0, 8'hFF, 24, -1);
    check("t2_rd_third", rx_words[2], 8'h33);

    // Abort after 4 data bits.
    tx_words = '{8'h5A};
    run_frame("t3_abort", 0, 1'b1, 8'h10, 4, -1);
    tx_words.delete();
    run_frame("t3_rd", 0, 1'b0, 8'h10, 8, -1);
    check("t3_rd_value", rx_words[0], 8'h00);

    // Mode 3 instance.
    tx_words = '{8'hA5};
    run_frame("t4_wr", 1, 1'b1, 8'h05, 8, -1);
    tx_words.delete();
    run_frame("t4_rd", 1, 1'b0, 8'h05, 8, -1);
    check("t4_rd_value", rx_words[0], 8'hA5);

    // Out-of-range address on the DEPTH=200 instance.
    tx_words = '{8'hAA};
    run_frame("t5_wr", 2, 1'b1, 8'hC8, 8, -1);
    tx_words.delete();
    run_frame("t5_rd", 2, 1'b0, 8'hC8, 8, -1);
    check("t5_rd_value", rx_words[0], 8'h00);

    // Randomized write bursts each followed by a read-back burst.
    for (int r = 0; r < 6; r++) begin
      id = int'($urandom_range(0, 2));
      a = 8'($urandom);
      if (id == 2 && r % 2 == 0) a = 8'($urandom_range(196, 203));
      n = int'($urandom_range(1, 3));
      tx_words.delete();
      for (int k = 0; k < n; k++) tx_words.push_back(8'($urandom));
      run_frame("rnd_wr", id, 1'b1, a, 8 * n, -1);
      tx_words.delete();
      run_frame("rnd_rd", id, 1'b0, a, 8 * n, -1);
    end

    // Reset in the middle of the address of a write, then a fresh frame.
    tx_words = '{8'h77};
    run_frame("t6_rst", 0, 1'b1, 8'h42, 8, 4);
    tx_words.delete();
    run_frame("t6_cleared", 0, 1'b0, 8'hE9, 8, -1);
    tx_words = '{8'h3C};
    run_frame("t6_wr", 0, 1'b1, 8'h01, 8, -1);
    check("t6_wr_data", wr_data[0], 8'h3C);
    tx_words.delete();
    run_frame("t6_rd", 0, 1'b0, 8'h01, 8, -1);
    check("t6_rd_value", rx_words[0], 8'h3C);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
